pc_redirect_unit: RTL and testbench
===================================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'hbfc00000, PC value after reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'hbfc00380, exception entry address.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port stall  input  1  fetch cannot accept a new PC this cycle.
REQ-007 SHALL have ports br_valid  input  1 / br_target  input  WIDTH  branch redirect.
REQ-008 SHALL have ports j_valid  input  1 / j_target  input  WIDTH  jump redirect.
REQ-009 SHALL have ports eret_valid  input  1 / epc  input  WIDTH  exception-return redirect.
REQ-010 SHALL have port exc_valid  input  1  exception redirect to EXC_VEC.
REQ-011 SHALL have port pc  output  WIDTH  registered current fetch PC.
REQ-012 SHALL have port pc_next  output  WIDTH  combinational value loaded at the next unstalled edge.
REQ-013 SHALL have port redirect_pending  output  1  a redirect is held in the pending buffer.
REQ-014 SHALL have port pc_misalign  output  1  registered flag, pc[1:0] != 0.

Function
REQ-015 Redirect priority SHALL be exc (4) > eret (3) > jump (2) > branch (1) > sequential pc+4 (0).
REQ-016 Sequential target SHALL be pc + 4, modulo 2^WIDTH; 32'hfffffffc wraps to 32'h00000000.
REQ-017 Unstalled cycle: pc_next SHALL be the target of the highest priority among live inputs and the pending entry; on equal priority the live input wins.
REQ-018 Unstalled cycle: pc SHALL load pc_next at the edge, and the pending buffer SHALL clear in the same edge.
REQ-019 Stalled cycle: pc SHALL hold, and pc_next SHALL equal the current pc.
REQ-020 Stalled cycle with a live redirect: the buffer SHALL capture the highest live redirect (priority and target) if its priority >= the stored priority; otherwise the buffer SHALL keep its contents.
REQ-021 The pending buffer SHALL be one entry deep; redirect_pending SHALL be 1 exactly while it holds a valid entry.
REQ-022 A redirect arriving in the cycle stall falls SHALL take effect at that edge with no extra latency; a redirect arriving in an unstalled cycle SHALL appear on pc after 1 edge.
REQ-023 Multiple simultaneous valids SHALL resolve per REQ-015; lower-priority targets SHALL be discarded.
REQ-024 exc_valid SHALL always select EXC_VEC regardless of stall history.

Reset
REQ-025 While resetn == 0 at a rising edge: pc SHALL become RESET_VEC, the pending buffer SHALL clear (redirect_pending = 0, stored priority = 0), and pc_misalign SHALL become 0.
REQ-026 Reset SHALL override stall and all redirect inputs, including a redirect pending mid-stall.
REQ-027 The first unstalled edge after resetn rises SHALL load RESET_VEC + 4 unless a redirect is live.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: pc_misalign SHALL be registered alongside pc and equal (pc_next[1:0] != 2'b00) at each load; the misaligned PC itself SHALL still be loaded unmodified.
REQ-029 Macro PC_ALIGN_CHECK_EN undefined: pc_misalign SHALL be constant 0 and no check logic SHALL be generated.

Verification
REQ-030 Reset then 3 unstalled cycles -> pc = bfc00000, bfc00004, bfc00008, bfc0000c.
REQ-031 br_valid=1, j_valid=1, j_target=80001000, br_target=80002000 in one cycle -> pc = 80001000 next edge.
REQ-032 stall=1; br 80002000 in cycle 1; jump 80003000 in cycle 2; branch 80004000 in cycle 3; stall=0 in cycle 4 -> redirect_pending=1 in cycles 2-4, pc = 80003000 after cycle-4 edge, then pending clears.
REQ-033 stall=1 with eret pending (epc=80000180); exc_valid=1 in the cycle stall drops -> pc = bfc00380, redirect_pending=0.
REQ-034 resetn=0 while stall=1 and a jump is pending -> pc = bfc00000, redirect_pending=0.
REQ-035 With PC_ALIGN_CHECK_EN, j_target=80000002 -> pc = 80000002, pc_misalign=1; next sequential pc = 80000006, still misaligned; without the macro pc_misalign stays 0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with prioritised redirects and a one-entry pending buffer that holds redirects across stalls.
// Optional misalignment flag is enabled by defining PC_ALIGN_CHECK_EN.
module pc_redirect_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = 32'hbfc00000,
    parameter logic [WIDTH-1:0]   EXC_VEC   = 32'hbfc00380
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             j_valid,
    input  logic [WIDTH-1:0] j_target,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             redirect_pending,
    output logic             pc_misalign
);

    typedef enum logic [2:0] {
        PRIO_SEQ  = 3'd0,
        PRIO_BR   = 3'd1,
        PRIO_J    = 3'd2,
        PRIO_ERET = 3'd3,
        PRIO_EXC  = 3'd4
    } prio_e;

    logic [WIDTH-1:0] pc_q;
    logic             pend_valid_q, pend_valid_d;
    prio_e            pend_prio_q, pend_prio_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    prio_e            live_prio;
    logic [WIDTH-1:0] live_tgt;
    logic             live_wins;

    always_comb begin
        live_prio = PRIO_SEQ;
        live_tgt  = '0;
        if (exc_valid) begin
            live_prio = PRIO_EXC;
            live_tgt  = EXC_VEC;
        end else if (eret_valid) begin
            live_prio = PRIO_ERET;
            live_tgt  = epc;
        end else if (j_valid) begin
            live_prio = PRIO_J;
            live_tgt  = j_target;
        end else if (br_valid) begin
            live_prio = PRIO_BR;
            live_tgt  = br_target;
        end
    end

    // The stored priority reads as PRIO_SEQ while empty, so any live redirect beats an empty buffer.
    assign live_wins = (live_prio != PRIO_SEQ) && (live_prio >= pend_prio_q);

    always_comb begin
        if (stall) begin
            pc_next = pc_q;
        end else if (live_wins) begin
            pc_next = live_tgt;
        end else if (pend_valid_q) begin
            pc_next = pend_tgt_q;
        end else begin
            pc_next = pc_q + WIDTH'(4);
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_prio_d  = pend_prio_q;
        pend_tgt_d   = pend_tgt_q;
        if (!stall) begin
            pend_valid_d = 1'b0;
            pend_prio_d  = PRIO_SEQ;
            pend_tgt_d   = '0;
        end else if (live_wins) begin
            pend_valid_d = 1'b1;
            pend_prio_d  = live_prio;
            pend_tgt_d   = live_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            pend_prio_q  <= PRIO_SEQ;
            pend_tgt_q   <= '0;
        end else begin
            pc_q         <= pc_next;
            pend_valid_q <= pend_valid_d;
            pend_prio_q  <= pend_prio_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    // The misaligned PC is still loaded as-is; only the flag reports it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            misalign_q <= 1'b0;
        end else if (!stall) begin
            misalign_q <= (pc_next[1:0] != 2'b00);
        end
    end

    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

    assign pc               = pc_q;
    assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomised and directed bench for pc_redirect_unit against a priority-list reference model.
// Define PC_ALIGN_CHECK_EN for both files to exercise the misalignment flag.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_VEC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC   = 32'hbfc00380;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        brValid, jValid, eretValid, excValid;
    logic [31:0] brTarget, jTarget, epc;
    logic [31:0] pc, pcNext;
    logic        redirectPending, pcMisalign;

    int checks   = 0;
    int failures = 0;

    // Reference state: the architectural PC plus an optional held redirect.
    logic [31:0] mPc;
    logic        mPendValid;
    int          mPendPrio;
    logic [31:0] mPendTgt;
    logic        mMis;

    pc_redirect_unit dut (
        .clk              (clk),
        .resetn           (resetn),
        .stall            (stall),
        .br_valid         (brValid),
        .br_target        (brTarget),
        .j_valid          (jValid),
        .j_target         (jTarget),
        .eret_valid       (eretValid),
        .epc              (epc),
        .exc_valid        (excValid),
        .pc               (pc),
        .pc_next          (pcNext),
        .redirect_pending (redirectPending),
        .pc_misalign      (pcMisalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Highest-priority live redirect, scanning the sources from weakest to strongest.
    task automatic bestLive(output int prio, output logic [31:0] tgt);
        logic        valids [4];
        logic [31:0] tgts   [4];
        valids = '{brValid, jValid, eretValid, excValid};
        tgts   = '{brTarget, jTarget, epc, EXC_VEC};
        prio = 0;
        tgt  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (valids[i]) begin
                prio = i + 1;
                tgt  = tgts[i];
            end
        end
    endtask

    function automatic logic misFlag(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic driveIdle();
        resetn    = 1'b1;
        stall     = 1'b0;
        brValid   = 1'b0;
        jValid    = 1'b0;
        eretValid = 1'b0;
        excValid  = 1'b0;
        brTarget  = 32'h0;
        jTarget   = 32'h0;
        epc       = 32'h0;
    endtask

    // One clock cycle with the currently driven inputs: check at negedge, advance the model after posedge.
    task automatic applyStimulus();
        int          liveP;
        logic [31:0] liveT;
        logic [31:0] expNext;
        bestLive(liveP, liveT);
        if (stall)
            expNext = mPc;
        else if (liveP > 0 && liveP >= (mPendValid ? mPendPrio : 0))
            expNext = liveT;
        else if (mPendValid)
            expNext = mPendTgt;
        else
            expNext = mPc + 32'd4;

        @(negedge clk);
        checkOutput("pc", pc, mPc);
        checkOutput("pending", {31'b0, redirectPending}, {31'b0, mPendValid});
        checkOutput("misalign", {31'b0, pcMisalign}, {31'b0, mMis});
        if (resetn)
            checkOutput("pc_next", pcNext, expNext);

        @(posedge clk);
        #1;
        if (!resetn) begin
            mPc        = RESET_VEC;
            mPendValid = 1'b0;
            mPendPrio  = 0;
            mMis       = 1'b0;
        end else if (!stall) begin
            mPc        = expNext;
            mPendValid = 1'b0;
            mPendPrio  = 0;
            mMis       = misFlag(expNext);
        end else if (liveP > 0 && liveP >= (mPendValid ? mPendPrio : 0)) begin
            mPendValid = 1'b1;
            mPendPrio  = liveP;
            mPendTgt   = liveT;
        end
    endtask

    task automatic doReset();
        driveIdle();
        resetn = 1'b0;
        applyStimulus();
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(7) != 0)
            t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        mPc = 32'h0; mPendValid = 1'b0; mPendPrio = 0; mPendTgt = 32'h0; mMis = 1'b0;
        driveIdle();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        mPc = RESET_VEC;

        // Reset vector then sequential fetch.
        doReset();
        checkOutput("req030_pc0", pc, 32'hbfc00000);
        checkOutput("req030_pend0", {31'b0, redirectPending}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus();
            checkOutput("req030_seq", pc, 32'hbfc00000 + 32'(4 * i));
        end

        // Jump beats branch in the same cycle.
        brValid = 1'b1; brTarget = 32'h80002000;
        jValid  = 1'b1; jTarget  = 32'h80001000;
        applyStimulus();
        checkOutput("req031_pc", pc, 32'h80001000);
        driveIdle();

        // Stalled redirects: weaker branch after a jump is dropped.
        stall = 1'b1; brValid = 1'b1; brTarget = 32'h80002000;
        applyStimulus();
        checkOutput("req032_pend1", {31'b0, redirectPending}, 32'h1);
        brValid = 1'b0; jValid = 1'b1; jTarget = 32'h80003000;
        applyStimulus();
        jValid = 1'b0; brValid = 1'b1; brTarget = 32'h80004000;
        applyStimulus();
        checkOutput("req032_pend3", {31'b0, redirectPending}, 32'h1);
        driveIdle();
        applyStimulus();
        checkOutput("req032_pc", pc, 32'h80003000);
        checkOutput("req032_clear", {31'b0, redirectPending}, 32'h0);

        // Exception in the release cycle beats a held eret.
        stall = 1'b1; eretValid = 1'b1; epc = 32'h80000180;
        applyStimulus();
        driveIdle();
        excValid = 1'b1;
        applyStimulus();
        checkOutput("req033_pc", pc, 32'hbfc00380);
        checkOutput("req033_pend", {31'b0, redirectPending}, 32'h0);
        driveIdle();

        // Reset overrides a held jump during stall.
        stall = 1'b1; jValid = 1'b1; jTarget = 32'h80005000;
        applyStimulus();
        jValid = 1'b0; resetn = 1'b0;
        applyStimulus();
        checkOutput("req034_pc", pc, 32'hbfc00000);
        checkOutput("req034_pend", {31'b0, redirectPending}, 32'h0);
        driveIdle();

        // Misaligned jump target and the sequential PC after it.
        jValid = 1'b1; jTarget = 32'h80000002;
        applyStimulus();
        checkOutput("req035_pc", pc, 32'h80000002);
        checkOutput("req035_mis", {31'b0, pcMisalign}, {31'b0, misFlag(32'h80000002)});
        driveIdle();
        applyStimulus();
        checkOutput("req035_seq", pc, 32'h80000006);
        checkOutput("req035_mis2", {31'b0, pcMisalign}, {31'b0, misFlag(32'h80000006)});

        // Sequential wrap at the top of the address space.
        jValid = 1'b1; jTarget = 32'hfffffffc;
        applyStimulus();
        driveIdle();
        applyStimulus();
        checkOutput("wrap_pc", pc, 32'h00000000);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            resetn    = ($urandom_range(49) != 0);
            stall     = ($urandom_range(1) == 1);
            brValid   = ($urandom_range(3) == 0);
            jValid    = ($urandom_range(4) == 0);
            eretValid = ($urandom_range(6) == 0);
            excValid  = ($urandom_range(9) == 0);
            brTarget  = randTarget();
            jTarget   = randTarget();
            epc       = randTarget();
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
